// File: rtl/alt_seq_pkg.sv
// Shared definitions for the alternating-bit generator, its detector and benches.
package alt_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Bits needed to hold a count of 0..n, never less than one bit.
  function automatic int cnt_w(input int n);
    int w;
    w = $clog2(n + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/alt_seq_gen_if.sv
// Request/status and serial-stream bundle between a requester and alt_seq_gen.
interface alt_seq_gen_if #(
  parameter int LEN_W = 4
) ();

  logic             start;
  logic [LEN_W-1:0] len;
  logic             first_bit;
  logic             abort;
  logic             ready;
  logic             busy;
  logic             out;
  logic             bit_valid;
  logic             done;

  modport master (
    output start, len, first_bit, abort,
    input  ready, busy, out, bit_valid, done
  );

  modport slave (
    input  start, len, first_bit, abort,
    output ready, busy, out, bit_valid, done
  );

endinterface

// File: rtl/alt_seq_gen_seq_down_counter.sv
// Loadable down-counter that stops at zero and flags when it holds zero.
module seq_down_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] count_r;

  // Load has priority over decrement; decrement saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {W{1'b0}};
    end else if (load) begin
      count_r <= load_val;
    end else if (dec && (count_r != {W{1'b0}})) begin
      count_r <= count_r - W'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == {W{1'b0}});

endmodule

// File: rtl/alt_seq_gen.sv
// Serial generator of a programmable-length alternating 0/1 sequence followed by
// a break of repeated last bits and a one-cycle completion pulse.
module alt_seq_gen
  import alt_seq_pkg::*;
#(
  parameter int   LEN_W      = 4,
  parameter int   GAP_CYCLES = 2,
  parameter logic IDLE_BIT   = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  alt_seq_gen_if.slave  bus
);

  localparam int GW = cnt_w(GAP_CYCLES);
  localparam logic [GW-1:0] GAP_LOAD = GW'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  state_e           state_r;
  logic             out_r;
  logic             bit_valid_r;
  logic             done_r;
  logic             ready_r;
  logic             busy_r;

  logic             len_load_s;
  logic [LEN_W-1:0] len_load_val_s;
  logic             len_dec_s;
  logic             len_zero_s;
  logic             gap_load_s;
  logic             gap_dec_s;
  logic             gap_zero_s;

  // Counters are loaded with count-1 so that the zero flag marks the final cycle.
  assign len_load_s     = (state_r == IDLE) && bus.start;
  assign len_load_val_s = bus.len - LEN_W'(1);
  assign len_dec_s      = (state_r == SEND) && !bus.abort && !len_zero_s;
  assign gap_load_s     = (state_r == SEND) && !bus.abort && len_zero_s;
  assign gap_dec_s      = (state_r == GAP) && !bus.abort && !gap_zero_s;

  seq_down_counter #(.W(LEN_W)) u_len_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (len_load_s),
    .load_val (len_load_val_s),
    .dec      (len_dec_s),
    .zero     (len_zero_s)
  );

  seq_down_counter #(.W(GW)) u_gap_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (gap_load_s),
    .load_val (GAP_LOAD),
    .dec      (gap_dec_s),
    .zero     (gap_zero_s)
  );

  // Control FSM; every output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      out_r       <= IDLE_BIT;
      bit_valid_r <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else if (bus.abort && (state_r != IDLE)) begin
      state_r     <= IDLE;
      out_r       <= IDLE_BIT;
      bit_valid_r <= 1'b0;
      done_r      <= 1'b0;
      ready_r     <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            if (bus.len != {LEN_W{1'b0}}) begin
              state_r     <= SEND;
              out_r       <= bus.first_bit;
              bit_valid_r <= 1'b1;
              done_r      <= 1'b0;
            end else begin
              state_r     <= DONE;
              out_r       <= IDLE_BIT;
              bit_valid_r <= 1'b0;
              done_r      <= 1'b1;
            end
          end else begin
            state_r     <= IDLE;
            out_r       <= IDLE_BIT;
            bit_valid_r <= 1'b0;
            done_r      <= 1'b0;
            ready_r     <= 1'b1;
            busy_r      <= 1'b0;
          end
        end
        SEND: begin
          if (len_zero_s) begin
            bit_valid_r <= 1'b0;
            if (GAP_CYCLES > 0) begin
              // The break repeats the last bit, so out_r is left untouched.
              state_r <= GAP;
            end else begin
              state_r <= DONE;
              out_r   <= IDLE_BIT;
              done_r  <= 1'b1;
            end
          end else begin
            out_r <= ~out_r;
          end
        end
        GAP: begin
          if (gap_zero_s) begin
            state_r <= DONE;
            out_r   <= IDLE_BIT;
            done_r  <= 1'b1;
          end else begin
            state_r <= GAP;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          out_r       <= IDLE_BIT;
          bit_valid_r <= 1'b0;
          done_r      <= 1'b0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          out_r       <= IDLE_BIT;
          bit_valid_r <= 1'b0;
          done_r      <= 1'b0;
          ready_r     <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.out       = out_r;
  assign bus.bit_valid = bit_valid_r;
  assign bus.done      = done_r;
  assign bus.ready     = ready_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_alt_seq_gen.sv
// Bench for alt_seq_gen: two instances (break of 2 and of 0 cycles) share stimulus
// and are checked every cycle against a timeline model of each transfer.
module tb_alt_seq_gen;

  logic clk;
  logic reset;

  alt_seq_gen_if #(.LEN_W(4)) bus0 ();
  alt_seq_gen_if #(.LEN_W(4)) bus1 ();

  alt_seq_gen #(.LEN_W(4), .GAP_CYCLES(2), .IDLE_BIT(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.slave)
  );

  alt_seq_gen #(.LEN_W(4), .GAP_CYCLES(0), .IDLE_BIT(1'b0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_cmp;
  int n_fail;
  int edge_n;

  // Per-instance record of the transfer in flight: acceptance edge, length, first bit.
  int gp  [2];
  bit act [2];
  int t0  [2];
  int ln  [2];
  bit fb  [2];

  function automatic int dur(input int m);
    return (ln[m] == 0) ? 1 : ln[m] + gp[m] + 1;
  endfunction

  // Cycle following edge e is transfer cycle e - t0 + 1 (the first bit is cycle 1).
  function automatic bit busy_at(input int m, input int e);
    return act[m] && ((e - t0[m] + 1) <= dur(m));
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed=%b expected=%b", tag, edge_n, obs, exp);
    end
  endtask

  task automatic check_inst(input int m, input logic o, input logic bv, input logic dn,
                            input logic rdy, input logic bsy);
    int  d;
    bit  b;
    bit  e_out;
    bit  e_bv;
    bit  e_done;
    string p;
    p      = (m == 0) ? "gap2" : "gap0";
    b      = busy_at(m, edge_n);
    d      = edge_n - t0[m] + 1;
    e_out  = 1'b0;
    e_bv   = 1'b0;
    e_done = 1'b0;
    if (b) begin
      if (ln[m] > 0 && d <= ln[m]) begin
        e_out = fb[m] ^ bit'((d - 1) % 2);
        e_bv  = 1'b1;
      end else if (ln[m] > 0 && d <= ln[m] + gp[m]) begin
        e_out = fb[m] ^ bit'((ln[m] - 1) % 2);
      end else begin
        e_done = 1'b1;
      end
    end
    chk({p, ".out"}, o, e_out);
    chk({p, ".bit_valid"}, bv, e_bv);
    chk({p, ".done"}, dn, e_done);
    chk({p, ".ready"}, rdy, !b);
    chk({p, ".busy"}, bsy, b);
  endtask

  // Apply one cycle of inputs, advance the model across the edge, then check.
  task automatic tick(input bit rs, input bit st, input int l, input bit f, input bit ab);
    bit was_busy [2];
    reset          = rs;
    bus0.start     = st;   bus1.start     = st;
    bus0.len       = 4'(l); bus1.len      = 4'(l);
    bus0.first_bit = f;    bus1.first_bit = f;
    bus0.abort     = ab;   bus1.abort     = ab;
    for (int m = 0; m < 2; m++) was_busy[m] = busy_at(m, edge_n);
    @(posedge clk);
    edge_n++;
    for (int m = 0; m < 2; m++) begin
      if (rs) begin
        act[m] = 1'b0;
      end else if (!was_busy[m] && st) begin
        act[m] = 1'b1;
        t0[m]  = edge_n;
        ln[m]  = l;
        fb[m]  = f;
      end else if (was_busy[m] && ab) begin
        act[m] = 1'b0;
      end
    end
    #1;
    n_vec++;
    check_inst(0, bus0.out, bus0.bit_valid, bus0.done, bus0.ready, bus0.busy);
    check_inst(1, bus1.out, bus1.bit_valid, bus1.done, bus1.ready, bus1.busy);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, $urandom_range(15, 0), $urandom_range(1, 0), 1'b0);
  endtask

  initial begin
    n_vec = 0; n_cmp = 0; n_fail = 0; edge_n = 0;
    gp[0] = 2; gp[1] = 0;
    for (int m = 0; m < 2; m++) begin
      act[m] = 1'b0; t0[m] = 0; ln[m] = 0; fb[m] = 1'b0;
    end
    reset = 1'b1;
    bus0.start = 1'b0; bus0.len = 4'd0; bus0.first_bit = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.len = 4'd0; bus1.first_bit = 1'b0; bus1.abort = 1'b0;
    #2;

    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 0, 1'b0, 1'b0);
    idle(2);

    // len=6, first bit 1
    tick(1'b0, 1'b1, 6, 1'b1, 1'b0);
    idle(11);

    // len=0 goes straight to the done pulse
    tick(1'b0, 1'b1, 0, 1'b1, 1'b0);
    idle(3);

    // start held high: back-to-back transfers with no queuing
    for (int i = 0; i < 16; i++) tick(1'b0, 1'b1, 3, 1'b0, 1'b0);
    idle(8);

    // abort during the third bit
    tick(1'b0, 1'b1, 6, 1'b1, 1'b0);
    idle(2);
    tick(1'b0, 1'b0, 6, 1'b1, 1'b1);
    idle(10);

    // maximum length, first bit 0
    tick(1'b0, 1'b1, 15, 1'b0, 1'b0);
    idle(20);

    // reset during the first break cycle of the gapped instance
    tick(1'b0, 1'b1, 2, 1'b1, 1'b0);
    idle(2);
    tick(1'b1, 1'b0, 2, 1'b1, 1'b0);
    idle(5);

    // abort together with start while idle: start wins
    tick(1'b0, 1'b1, 4, 1'b0, 1'b1);
    idle(9);

    for (int i = 0; i < 600; i++) begin
      tick(($urandom_range(63, 0) == 0),
           ($urandom_range(2, 0) == 0),
           $urandom_range(15, 0),
           $urandom_range(1, 0),
           ($urandom_range(15, 0) == 0));
    end
    idle(20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/alt_seq_gen.md
Name: alt_seq_gen

Overview:
- Serial transmitter for the alternating-0/1 pattern protocol. It is the generating end of the stream that the alternating-bit detector FSM consumes.
- On an accepted start request it emits a programmable-length alternating bit sequence, one bit per clock, on a single serial output.
- After the sequence it drives a fixed break (the last bit repeated), then reports completion.
- It feeds the detector `in` input directly in block-level and system benches.

Parameters:
- LEN_W, 4, width of the sequence-length input; maximum sequence length is 2**LEN_W-1.
- GAP_CYCLES, 2, number of break cycles after the sequence; 0 is legal and skips the break.
- IDLE_BIT, 1'b0, value of `out` whenever no sequence or break is being driven.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to send; accepted only when ready=1.
- len  input  LEN_W  number of alternating bits to send; sampled on acceptance.
- first_bit  input  1  value of the first emitted bit; sampled on acceptance.
- abort  input  1  synchronous cancel of an in-progress transfer.
- ready  output  1  high in IDLE only.
- busy  output  1  equals ~ready.
- out  output  1  serial bit stream to the detector.
- bit_valid  output  1  high on cycles carrying a sequence bit.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (sampled at posedge): state=IDLE, out=IDLE_BIT, bit_valid=0, done=0, ready=1, busy=0. All outputs are registered.
- States:
  - IDLE: waits for start. Acceptance happens at edge k when start=1 and state=IDLE. At that edge, len and first_bit are captured.
    - len>0: go to SEND.
    - len==0: go to DONE.
  - SEND: cycles k+1..k+len.
    - Cycle k+1 drives out=first_bit; each later SEND cycle drives out=~previous out.
    - bit_valid=1 throughout SEND.
    - A down-counter loaded with len decrements per bit. After the last bit, go to GAP if GAP_CYCLES>0, else DONE.
  - GAP: GAP_CYCLES cycles with out held at the last SEND bit (breaks the alternation) and bit_valid=0. Then go to DONE.
  - DONE: exactly one cycle with done=1, bit_valid=0, out=IDLE_BIT. Next state is IDLE.
- Completion timing:
  - len=0: done is high in cycle k+1.
  - len>0: done is high in cycle k+len+GAP_CYCLES+1.
- start is ignored in SEND, GAP and DONE. There is no queuing, and the first acceptance possible after DONE is the following IDLE cycle.
- abort=1 in SEND, GAP or DONE returns to IDLE at the next edge: out=IDLE_BIT, bit_valid=0, done=0. A done pulse already asserted in DONE still completes its cycle. abort in IDLE has no effect.
- abort and start together in IDLE: start wins (abort is a no-op in IDLE).
- reset has priority over abort and start; reset mid-transfer behaves like abort.
- Counter widths: the length counter is LEN_W bits. The gap counter is $clog2(GAP_CYCLES+1) bits, minimum 1. No wrap-around is possible because the counters stop at zero.
- Changes to len and first_bit after acceptance have no effect on the transfer.

Decomposition:
- Shared package alt_seq_pkg holds the state encoding constants: IDLE=0, SEND=1, GAP=2, DONE=3, on a 2-bit state. The detector and benches reuse this package.
- One natural sub-module, seq_down_counter, with parameterised width and load/decrement/zero flag. It is instantiated twice: once for length and once for gap.

Test Plan:
- Defaults; start=1 at edge k, len=6, first_bit=1 -> out 1,0,1,0,1,0 with bit_valid=1 in k+1..k+6; out 0,0 with bit_valid=0 in k+7..k+8; done=1 only in k+9; ready=1 in k+10.
- len=0, first_bit=1 -> bit_valid never asserts, out stays 0, done=1 in k+1, ready back in k+2.
- len=3, first_bit=0, start held high for the whole transfer -> exactly one transfer of 0,1,0, gap 0,0, a single done pulse, then a second transfer accepted in the first IDLE cycle after DONE.
- len=6; abort=1 during the 3rd bit (cycle k+3) -> out=0, bit_valid=0, ready=1 from k+4; done never asserts.
- len=15, first_bit=0, GAP_CYCLES=0 -> 15 alternating bits ending in 0, done in k+16; the detector bench sees the alternation flag assert.
- reset=1 asserted in a GAP cycle -> all outputs reach their reset values at the next edge; no done pulse.
